// File: rtl/posit_lut_loader.sv
// Runtime-loadable posit function table: streams 2**WIDTH words in over a
// valid/ready load port, then serves registered lookups with NaR pass-through.
module posit_lut_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             load_busy,
    output logic             load_done,
    output logic [15:0]      load_sum,
    output logic             table_valid,
    input  logic [WIDTH-1:0] in_posit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_posit,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int DEPTH = 2 ** WIDTH;
    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        VALID
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [15:0]      sum_q, sum_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_posit_q, out_posit_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        done_d      = 1'b0;
        out_posit_d = out_posit_q;
        out_valid_d = out_valid_q;

        load_busy   = (state_q == LOAD);
        table_valid = (state_q == VALID);
        load_ready  = (state_q == LOAD) && !load_start;
        in_ready    = table_valid && (!out_valid_q || out_ready);
        wr_en       = load_valid && load_ready;
        rd_en       = in_valid && in_ready;

        // A start pulse wins over any word presented in the same cycle.
        if (load_start) begin
            state_d = LOAD;
            addr_d  = '0;
            sum_d   = '0;
        end else if (wr_en) begin
            addr_d = addr_q + 1'b1;
            sum_d  = sum_q + 16'(load_data);
            if (addr_q == {WIDTH{1'b1}}) begin
                state_d = VALID;
                done_d  = 1'b1;
            end
        end

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_posit_d = (in_posit == NAR) ? NAR : mem_q[in_posit];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            addr_q      <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            out_posit_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
            out_posit_q <= out_posit_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: the table array has no reset; table_valid gates every read, and
    // leaving it out keeps the array mappable onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_q[addr_q] <= load_data;
        end
    end

    assign load_done = done_q;
    assign load_sum  = sum_q;
    assign out_posit = out_posit_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_posit_lut_loader.sv
// Self-checking bench for posit_lut_loader: directed load/lookup scenarios plus
// randomized data, load bubbles and output backpressure against a table model.
module tb_posit_lut_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic [15:0] load_sum;
    logic        table_valid;
    logic [7:0]  in_posit;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_posit;
    logic        out_valid;
    logic        out_ready;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_sum;

    posit_lut_loader #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_sum   (load_sum),
        .table_valid(table_valid),
        .in_posit   (in_posit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_posit  (out_posit),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] ref_lookup(input logic [7:0] idx);
        return (idx == 8'h80) ? 8'h80 : ref_mem[idx];
    endfunction

    function automatic logic [7:0] data_for(input int dmode, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (dmode)
            0:       return kk ^ 8'h5A;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Pulse load_start (optionally with a word that must be dropped), then
    // check the first LOAD cycle.
    task automatic start_load(input bit with_word);
        load_start = 1'b1;
        load_valid = with_word;
        load_data  = 8'hAA;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        exp_sum    = 16'h0;
        #1;
        check("start_busy", load_busy, 1);
        check("start_ready", load_ready, 1);
        check("start_table_valid", table_valid, 0);
        check("start_in_ready", in_ready, 0);
        check("start_sum", load_sum, 0);
    endtask

    // bmode: 0 back-to-back, 1 valid on odd cycles after start, 2 random.
    task automatic feed_words(input int count, input int dmode, input int bmode, input bit full);
        int         k = 0;
        int         cyc = 1;
        bit         early_done = 1'b0;
        bit         early_tv = 1'b0;
        bit         v;
        logic [7:0] d;
        while (k < count) begin
            case (bmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = data_for(dmode, k);
            load_valid = v;
            load_data  = d;
            if (v) begin
                ref_mem[k] = d;
                exp_sum    = exp_sum + 16'(d);
                k++;
            end
            tick();
            cyc++;
            if (k < count) begin
                if (load_done) early_done = 1'b1;
                if (table_valid) early_tv = 1'b1;
            end
        end
        load_valid = 1'b0;
        check("no_early_done", early_done, 0);
        check("no_early_table_valid", early_tv, 0);
        check("load_sum", load_sum, exp_sum);
        if (full) begin
            check("done_pulse", load_done, 1);
            check("table_valid_rise", table_valid, 1);
            check("busy_clear", load_busy, 0);
            tick();
            check("done_one_cycle", load_done, 0);
        end
    endtask

    task automatic lookup_one(input logic [7:0] idx, input logic [7:0] exp);
        in_valid  = 1'b1;
        in_posit  = idx;
        out_ready = 1'b1;
        #1;
        check("lookup_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("lookup_out_valid", out_valid, 1);
        check("lookup_out_posit", out_posit, exp);
    endtask

    task automatic stream_all();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_posit = 8'(i);
            tick();
            check("stream_out_valid", out_valid, 1);
            check("stream_out_posit", out_posit, ref_lookup(8'(i)));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", out_valid, 0);
    endtask

    initial begin
        logic [7:0] held;
        bit         ov_m;
        logic [7:0] op_m;
        bit         iv, orr, acc;
        logic [7:0] idx;

        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        in_valid   = 1'b0;
        in_posit   = 8'h00;
        out_ready  = 1'b0;
        exp_sum    = 16'h0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_posit", out_posit, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_busy", load_busy, 0);

        // Lookup attempt against an empty table.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_posit  = 8'h40;
        out_ready = 1'b1;
        #1;
        check("empty_in_ready", in_ready, 0);
        check("empty_out_valid", out_valid, 0);
        check("empty_table_valid", table_valid, 0);
        check("empty_load_sum", load_sum, 0);
        check("empty_load_ready", load_ready, 0);
        tick();
        check("empty_no_result", out_valid, 0);
        in_valid = 1'b0;

        // Back-to-back XOR 0x5A load.
        start_load(1'b0);
        feed_words(256, 0, 0, 1'b1);
        check("xor_sum_const", load_sum, 16'h7F80);
        lookup_one(8'h03, 8'h59);
        lookup_one(8'h80, 8'h80);

        // Output backpressure on a lookup of 0x10.
        in_valid  = 1'b1;
        in_posit  = 8'h10;
        out_ready = 1'b1;
        tick();
        in_posit  = 8'h11;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_posit", out_posit, 8'h4A);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_posit", out_posit, 8'h4B);

        // Same load with load_valid on alternate cycles, then full sweep.
        start_load(1'b0);
        feed_words(256, 0, 1, 1'b1);
        stream_all();

        // Pending result survives load_start; restart after 100 words.
        in_valid  = 1'b1;
        in_posit  = 8'h20;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        held      = ref_lookup(8'h20);
        start_load(1'b0);
        check("held_out_valid", out_valid, 1);
        check("held_out_posit", out_posit, held);
        out_ready = 1'b1;
        feed_words(100, 2, 0, 1'b0);
        check("partial_out_drained", out_valid, 0);
        start_load(1'b1);
        feed_words(256, 1, 0, 1'b1);
        check("ff_sum_const", load_sum, 16'hFF00);
        stream_all();

        // Reset in the middle of a load.
        start_load(1'b0);
        feed_words(50, 0, 0, 1'b0);
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h33;
        tick();
        load_valid = 1'b0;
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_ready", load_ready, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_table_valid", table_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_posit", out_posit, 0);
        check("mid_rst_sum", load_sum, 0);
        reset = 1'b0;
        tick();

        // Random contents with random bubbles, then random lookups.
        start_load(1'b0);
        feed_words(256, 2, 2, 1'b1);
        stream_all();
        ov_m = 1'b0;
        op_m = 8'h00;
        for (int n = 0; n < 300; n++) begin
            iv  = 1'($urandom_range(0, 1));
            orr = $urandom_range(0, 2) != 0;
            idx = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            in_valid  = iv;
            in_posit  = idx;
            out_ready = orr;
            #1;
            check("rand_in_ready", in_ready, !ov_m || orr);
            acc = iv && (!ov_m || orr);
            tick();
            if (acc) begin
                ov_m = 1'b1;
                op_m = ref_lookup(idx);
            end else if (orr) begin
                ov_m = 1'b0;
            end
            check("rand_out_valid", out_valid, ov_m);
            if (ov_m) check("rand_out_posit", out_posit, op_m);
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
